// File: rtl/rpc_cfg_init.sv
// Boot-time register write sequencer in front of a regbus controller port; passes the
// external regbus through once done. Define RPC_CFG_INIT_READBACK_EN to read back each entry.
module rpc_cfg_init #(
    parameter int unsigned NUM_CFG = 4,
    parameter logic [48*((NUM_CFG > 0) ? NUM_CFG : 1)-1:0] CFG_ADDR = '0,
    parameter logic [32*((NUM_CFG > 0) ? NUM_CFG : 1)-1:0] CFG_DATA = '0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [47:0] ext_addr_i,
    input  logic        ext_write_i,
    input  logic [31:0] ext_wdata_i,
    input  logic [3:0]  ext_wstrb_i,
    input  logic        ext_valid_i,
    output logic [31:0] ext_rdata_o,
    output logic        ext_ready_o,
    output logic        ext_error_o,
    output logic [47:0] reg_addr_o,
    output logic        reg_write_o,
    output logic [31:0] reg_wdata_o,
    output logic [3:0]  reg_wstrb_o,
    output logic        reg_valid_o,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_ready_i,
    input  logic        reg_error_i,
    input  logic        reinit_i,
    output logic        init_done_o,
    output logic        init_error_o
);

    localparam int unsigned IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = (NUM_CFG > 0) ? IDX_W'(NUM_CFG - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
`ifdef RPC_CFG_INIT_READBACK_EN
        S_READ  = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_reinit_pend;
    logic             w_reinit_pend_nxt;
    logic             r_init_error;
    logic             w_init_error_nxt;
    logic             w_advance;
    logic             w_reinit_req;
    logic [47:0]      w_entry_addr;
    logic [31:0]      w_entry_data;

    assign w_entry_addr = CFG_ADDR[48*int'(r_idx) +: 48];
    assign w_entry_data = CFG_DATA[32*int'(r_idx) +: 32];
    assign init_done_o  = (r_state == S_DONE);
    assign init_error_o = r_init_error;

    // NOTE: every output and next-state signal gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_reinit_pend_nxt = r_reinit_pend;
        w_init_error_nxt  = r_init_error;
        w_advance         = 1'b0;
        w_reinit_req      = 1'b0;
        reg_addr_o        = '0;
        reg_write_o       = 1'b0;
        reg_wdata_o       = '0;
        reg_wstrb_o       = '0;
        reg_valid_o       = 1'b0;
        ext_rdata_o       = '0;
        ext_ready_o       = 1'b0;
        ext_error_o       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_idx_nxt   = '0;
                w_state_nxt = (NUM_CFG == 0) ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                reg_valid_o = 1'b1;
                reg_write_o = 1'b1;
                reg_wstrb_o = 4'hF;
                reg_addr_o  = w_entry_addr;
                reg_wdata_o = w_entry_data;
                if (reg_ready_i) begin
                    if (reg_error_i) w_init_error_nxt = 1'b1;
`ifdef RPC_CFG_INIT_READBACK_EN
                    w_state_nxt = S_READ;
`else
                    w_advance = 1'b1;
`endif
                end
            end
`ifdef RPC_CFG_INIT_READBACK_EN
            S_READ: begin
                reg_valid_o = 1'b1;
                reg_addr_o  = w_entry_addr;
                if (reg_ready_i) begin
                    if (reg_error_i || (reg_rdata_i != w_entry_data)) w_init_error_nxt = 1'b1;
                    w_advance = 1'b1;
                end
            end
`endif
            S_DONE: begin
                reg_addr_o   = ext_addr_i;
                reg_write_o  = ext_write_i;
                reg_wdata_o  = ext_wdata_i;
                reg_wstrb_o  = ext_wstrb_i;
                reg_valid_o  = ext_valid_i;
                ext_rdata_o  = reg_rdata_i;
                ext_ready_o  = reg_ready_i;
                ext_error_o  = reg_error_i;
                // A reinit seen mid-transfer waits until the external master drops valid.
                w_reinit_req = reinit_i || r_reinit_pend;
                if (w_reinit_req && !ext_valid_i) begin
                    w_state_nxt       = S_IDLE;
                    w_idx_nxt         = '0;
                    w_init_error_nxt  = 1'b0;
                    w_reinit_pend_nxt = 1'b0;
                end else if (w_reinit_req) begin
                    w_reinit_pend_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_advance) begin
            if (r_idx == LAST_IDX) begin
                w_state_nxt = S_DONE;
            end else begin
                w_idx_nxt   = r_idx + 1'b1;
                w_state_nxt = S_WRITE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_reinit_pend <= 1'b0;
            r_init_error  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_reinit_pend <= w_reinit_pend_nxt;
            r_init_error  <= w_init_error_nxt;
        end
    end

endmodule

// File: tb/tb_rpc_cfg_init.sv
// Randomized self-checking bench for rpc_cfg_init: transaction-queue model of the boot
// sequence, sticky error flag, DONE passthrough, reinit handling and mid-sequence reset.
module tb_rpc_cfg_init;

    localparam int NUM = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [47:0] ext_addr_i = '0;
    logic        ext_write_i = 1'b0;
    logic [31:0] ext_wdata_i = '0;
    logic [3:0]  ext_wstrb_i = '0;
    logic        ext_valid_i = 1'b0;
    logic [31:0] ext_rdata_o;
    logic        ext_ready_o;
    logic        ext_error_o;
    logic [47:0] reg_addr_o;
    logic        reg_write_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic        reg_valid_o;
    logic [31:0] reg_rdata_i = '0;
    logic        reg_ready_i = 1'b0;
    logic        reg_error_i = 1'b0;
    logic        reinit_i = 1'b0;
    logic        init_done_o;
    logic        init_error_o;

    int n_checks = 0;
    int n_errs   = 0;

    logic [47:0] m_addr [NUM] = '{48'h0, 48'h4, 48'h8};
    logic [31:0] m_data [NUM] = '{32'h11, 32'h22, 32'h33};

    typedef struct {
        bit wr;
        int idx;
    } txn_t;

    txn_t q[$];

    always #5 clk_i = ~clk_i;

    rpc_cfg_init #(
        .NUM_CFG (NUM),
        .CFG_ADDR({48'h8, 48'h4, 48'h0}),
        .CFG_DATA({32'h33, 32'h22, 32'h11})
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .ext_addr_i  (ext_addr_i),
        .ext_write_i (ext_write_i),
        .ext_wdata_i (ext_wdata_i),
        .ext_wstrb_i (ext_wstrb_i),
        .ext_valid_i (ext_valid_i),
        .ext_rdata_o (ext_rdata_o),
        .ext_ready_o (ext_ready_o),
        .ext_error_o (ext_error_o),
        .reg_addr_o  (reg_addr_o),
        .reg_write_o (reg_write_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wstrb_o (reg_wstrb_o),
        .reg_valid_o (reg_valid_o),
        .reg_rdata_i (reg_rdata_i),
        .reg_ready_i (reg_ready_i),
        .reg_error_i (reg_error_i),
        .reinit_i    (reinit_i),
        .init_done_o (init_done_o),
        .init_error_o(init_error_o)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, want, $time);
        end
    endtask

    task automatic randomize_ext();
        ext_addr_i  = {16'($urandom()), $urandom()};
        ext_write_i = 1'($urandom_range(1));
        ext_wdata_i = $urandom();
        ext_wstrb_i = 4'($urandom());
        ext_valid_i = 1'($urandom_range(1));
    endtask

    // Drives one full boot sequence from its first request cycle and checks it against the
    // expected transaction list; the entry at stall_idx is held off for stall_n cycles.
    task automatic run_boot(input int stall_pct, input int err_pct, input int force_err_idx,
                            input int stall_idx, input int stall_n);
        txn_t t;
        bit   exp_err = 1'b0;
        bit   go;
        int   budget = 300;
        int   held = 0;
        q.delete();
        for (int i = 0; i < NUM; i++) begin
            t.wr = 1'b1; t.idx = i; q.push_back(t);
`ifdef RPC_CFG_INIT_READBACK_EN
            t.wr = 1'b0; t.idx = i; q.push_back(t);
`endif
        end
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk_i);
            budget--;
            check("req_valid", reg_valid_o, 1);
            check("req_addr", reg_addr_o, m_addr[q[0].idx]);
            check("req_write", reg_write_o, q[0].wr);
            if (q[0].wr) begin
                check("req_wdata", reg_wdata_o, m_data[q[0].idx]);
                check("req_wstrb", reg_wstrb_o, 4'hF);
            end
            check("ext_ready_stall", ext_ready_o, 0);
            check("ext_rdata_stall", ext_rdata_o, 0);
            check("ext_error_stall", ext_error_o, 0);
            check("done_low", init_done_o, 0);
            check("err_sticky", init_error_o, exp_err);
            if (q[0].idx == stall_idx && q[0].wr && held < stall_n) begin
                go = 1'b0;
                held++;
            end else begin
                go = ($urandom_range(99) >= stall_pct);
            end
            randomize_ext();
            reinit_i    = ($urandom_range(7) == 0);
            reg_ready_i = go;
            reg_error_i = go && ((q[0].wr && q[0].idx == force_err_idx) ||
                                 ($urandom_range(99) < err_pct));
            reg_rdata_i = m_data[q[0].idx];
            if (!q[0].wr && $urandom_range(99) < err_pct) reg_rdata_i = 32'h34;
            if (go) begin
                if (reg_error_i) exp_err = 1'b1;
                if (!q[0].wr && reg_rdata_i != m_data[q[0].idx]) exp_err = 1'b1;
                void'(q.pop_front());
            end
        end
        if (q.size() != 0) check("boot_timeout", q.size(), 0);
        @(negedge clk_i);
        reg_ready_i = 1'b0;
        reg_error_i = 1'b0;
        reinit_i    = 1'b0;
        ext_valid_i = 1'b0;
        check("done_high", init_done_o, 1);
        check("err_final", init_error_o, exp_err);
    endtask

    task automatic reinit_clean();
        @(negedge clk_i);
        ext_valid_i = 1'b0;
        reinit_i    = 1'b1;
        @(negedge clk_i);
        reinit_i = 1'b0;
        check("reinit_done_low", init_done_o, 0);
        check("reinit_err_clear", init_error_o, 0);
        check("reinit_idle_valid", reg_valid_o, 0);
    endtask

    task automatic passthru(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            randomize_ext();
            reg_rdata_i = $urandom();
            reg_ready_i = 1'($urandom_range(1));
            reg_error_i = 1'($urandom_range(1));
            #1;
            check("pt_addr", reg_addr_o, ext_addr_i);
            check("pt_write", reg_write_o, ext_write_i);
            check("pt_wdata", reg_wdata_o, ext_wdata_i);
            check("pt_wstrb", reg_wstrb_o, ext_wstrb_i);
            check("pt_valid", reg_valid_o, ext_valid_i);
            check("pt_rdata", ext_rdata_o, reg_rdata_i);
            check("pt_ready", ext_ready_o, reg_ready_i);
            check("pt_error", ext_error_o, reg_error_i);
        end
        @(negedge clk_i);
        ext_addr_i  = 48'h4;
        ext_write_i = 1'b0;
        ext_valid_i = 1'b1;
        reg_rdata_i = 32'hABCD;
        reg_ready_i = 1'b1;
        reg_error_i = 1'b0;
        #1;
        check("pt_read_rdata", ext_rdata_o, 32'hABCD);
        check("pt_read_addr", reg_addr_o, 48'h4);
        @(negedge clk_i);
        ext_valid_i = 1'b0;
        reg_ready_i = 1'b0;
    endtask

    initial begin
        // Reset hold: outputs quiet whatever the inputs do.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            randomize_ext();
            reg_ready_i = 1'b1;
            reg_rdata_i = $urandom();
            reinit_i    = 1'($urandom_range(1));
            #1;
            check("rst_valid", reg_valid_o, 0);
            check("rst_ready", ext_ready_o, 0);
            check("rst_rdata", ext_rdata_o, 0);
            check("rst_addr", reg_addr_o, 0);
            check("rst_done", init_done_o, 0);
            check("rst_err", init_error_o, 0);
        end
        @(negedge clk_i);
        reinit_i    = 1'b0;
        reg_ready_i = 1'b0;
        rst_ni      = 1'b1;
        #1;
        check("idle_valid", reg_valid_o, 0);

        run_boot(0, 0, -1, -1, 0);
        passthru(8);

        reinit_clean();
        run_boot(0, 0, -1, 1, 5);

        reinit_clean();
        run_boot(0, 0, 0, -1, 0);

        // Reinit while an external transfer is in flight.
        @(negedge clk_i);
        ext_addr_i  = 48'h4;
        ext_valid_i = 1'b1;
        reinit_i    = 1'b1;
        reg_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            reinit_i = 1'b0;
            check("pend_done_hold", init_done_o, 1);
        end
        ext_valid_i = 1'b0;
        @(negedge clk_i);
        check("pend_reinit_done", init_done_o, 0);
        check("pend_reinit_err", init_error_o, 0);
        run_boot(30, 10, -1, -1, 0);

        // Reset while entry 1 is in flight.
        reinit_clean();
        @(negedge clk_i);
        check("mid_entry0", reg_addr_o, 48'h0);
        reg_ready_i = 1'b1;
        reg_error_i = 1'b1;
        @(negedge clk_i);
        reg_ready_i = 1'b0;
        reg_error_i = 1'b0;
        check("mid_entry1", reg_addr_o, 48'h4);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", reg_valid_o, 0);
        check("mid_rst_addr", reg_addr_o, 0);
        check("mid_rst_err", init_error_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_boot(20, 0, -1, -1, 0);

        for (int r = 0; r < 4; r++) begin
            reinit_clean();
            run_boot(int'($urandom_range(50)), int'($urandom_range(20)), -1,
                     int'($urandom_range(NUM - 1)), int'($urandom_range(4)));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/rpc_cfg_init.md
RPC_CFG_INIT -- requirements
Module: rpc_cfg_init

Interface
REQ-001 SHALL have parameter NUM_CFG, default 4, meaning the number of boot-time register writes (0..16).
REQ-002 SHALL have parameter CFG_ADDR, default all-zero, meaning the packed NUM_CFG x 48-bit write addresses; entry 0 occupies the LSBs.
REQ-003 SHALL have parameter CFG_DATA, default all-zero, meaning the packed NUM_CFG x 32-bit write data; entry 0 occupies the LSBs.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports ext_addr_i (48), ext_write_i (1), ext_wdata_i (32), ext_wstrb_i (4) and ext_valid_i (1), all inputs: the external regbus request.
REQ-007 SHALL have ports ext_rdata_o (32), ext_ready_o (1) and ext_error_o (1), all outputs: the external regbus response.
REQ-008 SHALL have ports reg_addr_o (48), reg_write_o (1), reg_wdata_o (32), reg_wstrb_o (4) and reg_valid_o (1), all outputs: the request towards the controller regbus port.
REQ-009 SHALL have ports reg_rdata_i (32), reg_ready_i (1) and reg_error_i (1), all inputs: the controller regbus response.
REQ-010 SHALL have port reinit_i, input, 1 bit: single-cycle pulse requesting a re-run of the sequence.
REQ-011 SHALL have port init_done_o, output, 1 bit: the sequence has completed and external passthrough is active.
REQ-012 SHALL have port init_error_o, output, 1 bit: sticky flag, set if any sequence access failed.

Function
REQ-013 SHALL implement the states IDLE, WRITE, READ and DONE; READ exists only with the macro defined in REQ-029.
REQ-014 SHALL move from IDLE to WRITE with index 0 on the first clock after reset release, or from IDLE to DONE if NUM_CFG=0.
REQ-015 In WRITE, SHALL drive reg_valid_o=1, reg_write_o=1, reg_wstrb_o=4'hF, and addr/data taken from entry[index].
REQ-016 SHALL hold the WRITE request stable until reg_ready_i=1; the transfer completes in that cycle.
REQ-017 On write completion with reg_error_i=1, SHALL set init_error_o and continue the sequence without retrying.
REQ-018 On the last completion (index=NUM_CFG-1), SHALL enter DONE; otherwise it SHALL increment index and issue the next entry in the following cycle.
REQ-019 Outside DONE, SHALL drive ext_ready_o=0, ext_error_o=0 and ext_rdata_o=0, stalling the external master.
REQ-020 In DONE, SHALL pass reg_* = ext_* and ext_* = reg_* combinationally, with zero latency.
REQ-021 SHALL assert init_done_o exactly while in DONE.
REQ-022 On reinit_i=1 in DONE with ext_valid_i=0, SHALL go to IDLE next cycle, clear init_error_o and restart at index 0.
REQ-023 On reinit_i=1 with ext_valid_i=1, SHALL record the request as pending, finish the external transfer, and re-init on the first cycle with ext_valid_i=0.
REQ-024 SHALL ignore reinit_i outside DONE.
REQ-025 SHALL size the index counter to clog2(NUM_CFG) with a minimum of 1 bit; the index SHALL never wrap past NUM_CFG-1.

Reset
REQ-026 On rst_ni=0, SHALL asynchronously force state IDLE, index 0, reinit pending 0, init_done_o=0 and init_error_o=0.
REQ-027 During reset, SHALL drive reg_valid_o=0 and ext_ready_o=0, with all data outputs 0.
REQ-028 On a reset mid-sequence, SHALL drop the in-flight request immediately and restart from entry 0 after release.

Configuration
REQ-029 With RPC_CFG_INIT_READBACK_EN defined, each completed write SHALL be followed by a READ state issuing reg_write_o=0 to the same address.
REQ-030 In READ, on completion, SHALL set init_error_o if reg_rdata_i != CFG_DATA[index] or reg_error_i=1, then advance per REQ-018.
REQ-031 Without RPC_CFG_INIT_READBACK_EN, the READ state and its compare logic SHALL not exist; each write advances directly.

Verification
REQ-032 Boot, NUM_CFG=3, entries {0x0:0x11, 0x4:0x22, 0x8:0x33}, reg_ready_i=1 always -> three write transfers in consecutive cycles; init_done_o rises the cycle after the third write.
REQ-033 Stall entry 1 with reg_ready_i=0 for 5 cycles -> address 0x4 and data 0x22 held stable for 6 cycles; ext_ready_o stays 0 throughout.
REQ-034 reg_error_i=1 on entry 0 -> init_error_o=1 sticky; entries 1 and 2 still issued; init_done_o=1 at the end.
REQ-035 In DONE, external read of 0x4 with reg_rdata_i=0xABCD -> ext_rdata_o=0xABCD in the same cycle; then reinit_i during ext_valid_i=1 -> re-init starts the cycle after ext_valid_i falls.
REQ-036 Reset asserted during entry 1 -> reg_valid_o=0 immediately; after release the sequence restarts at 0x0.
REQ-037 Readback build, entry 2 read returns 0x34 -> init_error_o=1; init_done_o=1 after 6 transfers in total.
